// File: rtl/cgra_context_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// cgra_context_sequencer_pkg : widths, DM control field layout, sequencer states
// Revision: 1.0
// ============================================================================
package cgra_context_sequencer_pkg;

    localparam int C_NUM_PE    = 4;
    localparam int C_PE_CFG_W  = 7;
    localparam int C_DM_CTRL_W = 8;
    localparam int C_CM_ADDR_W = 6;
    localparam int C_LOOP_W    = 8;

    localparam int C_DM_RD_BIT   = 0;
    localparam int C_DM_WR_BIT   = 1;
    localparam int C_DM_ADDR_LSB = 2;

    function automatic int ctx_width(input int num_pe, input int pe_cfg_w, input int dm_ctrl_w);
        return num_pe * (pe_cfg_w + dm_ctrl_w);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/cgra_context_sequencer_if.sv
`default_nettype none
// ============================================================================
// cgra_context_sequencer_if : run control, context memory and array config bus
// Revision: 1.0
// ============================================================================
interface cgra_context_sequencer_if
    import cgra_context_sequencer_pkg::*;
#(
    parameter int NUM_PE    = C_NUM_PE,
    parameter int PE_CFG_W  = C_PE_CFG_W,
    parameter int DM_CTRL_W = C_DM_CTRL_W,
    parameter int CM_ADDR_W = C_CM_ADDR_W,
    parameter int LOOP_W    = C_LOOP_W
) ();
    localparam int CTX_W = ctx_width(NUM_PE, PE_CFG_W, DM_CTRL_W);

    logic                        start_i;
    logic [CM_ADDR_W-1:0]        start_addr_i;
    logic [CM_ADDR_W-1:0]        end_addr_i;
    logic [LOOP_W-1:0]           loop_cnt_i;
    logic                        stall_i;
    logic                        abort_i;
    logic                        rd_cm_en_o;
    logic [CM_ADDR_W-1:0]        cm_addr_o;
    logic [CTX_W-1:0]            rd_cm_data_i;
    logic [NUM_PE*PE_CFG_W-1:0]  pe_config_o;
    logic [NUM_PE*DM_CTRL_W-1:0] dm_control_o;
    logic                        ctx_valid_o;
    logic                        busy_o;
    logic                        done_o;
    logic                        err_o;
    logic [LOOP_W-1:0]           iter_o;

    modport slave (
        input  start_i, start_addr_i, end_addr_i, loop_cnt_i, stall_i, abort_i, rd_cm_data_i,
        output rd_cm_en_o, cm_addr_o, pe_config_o, dm_control_o, ctx_valid_o, busy_o,
               done_o, err_o, iter_o
    );

    modport master (
        output start_i, start_addr_i, end_addr_i, loop_cnt_i, stall_i, abort_i, rd_cm_data_i,
        input  rd_cm_en_o, cm_addr_o, pe_config_o, dm_control_o, ctx_valid_o, busy_o,
               done_o, err_o, iter_o
    );
endinterface
`default_nettype wire

// File: rtl/cgra_context_sequencer_unpack.sv
`default_nettype none
// ============================================================================
// cgra_context_sequencer_unpack : slices a context word into PE/DM lanes, NOP when invalid
// Revision: 1.0
// ============================================================================
module cgra_context_sequencer_unpack
    import cgra_context_sequencer_pkg::*;
#(
    parameter int NUM_PE    = C_NUM_PE,
    parameter int PE_CFG_W  = C_PE_CFG_W,
    parameter int DM_CTRL_W = C_DM_CTRL_W,
    parameter int CTX_W     = ctx_width(NUM_PE, PE_CFG_W, DM_CTRL_W)
) (
    input  wire logic                        ctx_valid_i,
    input  wire logic [CTX_W-1:0]            ctx_word_i,
    output logic      [NUM_PE*PE_CFG_W-1:0]  pe_config_o,
    output logic      [NUM_PE*DM_CTRL_W-1:0] dm_control_o
);
    localparam int PE_BUS_W = NUM_PE * PE_CFG_W;

    for (genvar n = 0; n < NUM_PE; n++) begin : g_lane
        logic [PE_CFG_W-1:0]  w_pe;
        logic [DM_CTRL_W-1:0] w_dm;

        assign w_pe = ctx_word_i[n*PE_CFG_W +: PE_CFG_W];
        assign w_dm = ctx_word_i[PE_BUS_W + n*DM_CTRL_W +: DM_CTRL_W];

        assign pe_config_o[n*PE_CFG_W +: PE_CFG_W] = ctx_valid_i ? w_pe : '0;

        // Each DM field is gated so no stray rd/wr strobe reaches a memory during a NOP.
        assign dm_control_o[n*DM_CTRL_W + C_DM_RD_BIT] = ctx_valid_i & w_dm[C_DM_RD_BIT];
        assign dm_control_o[n*DM_CTRL_W + C_DM_WR_BIT] = ctx_valid_i & w_dm[C_DM_WR_BIT];
        assign dm_control_o[n*DM_CTRL_W + C_DM_ADDR_LSB +: DM_CTRL_W-C_DM_ADDR_LSB] =
            ctx_valid_i ? w_dm[DM_CTRL_W-1:C_DM_ADDR_LSB] : '0;
    end

endmodule
`default_nettype wire

// File: rtl/cgra_context_sequencer.sv
`default_nettype none
// ============================================================================
// cgra_context_sequencer : autonomous looping context-memory sequencer for the CGRA
// Revision: 1.0
// ============================================================================
module cgra_context_sequencer
    import cgra_context_sequencer_pkg::*;
#(
    parameter int NUM_PE    = C_NUM_PE,
    parameter int PE_CFG_W  = C_PE_CFG_W,
    parameter int DM_CTRL_W = C_DM_CTRL_W,
    parameter int CM_ADDR_W = C_CM_ADDR_W,
    parameter int LOOP_W    = C_LOOP_W
) (
    input  wire logic               clk,
    input  wire logic               reset,
    cgra_context_sequencer_if.slave bus
);
    localparam int CTX_W = ctx_width(NUM_PE, PE_CFG_W, DM_CTRL_W);

    seq_state_e           state_q, state_d;
    logic [CM_ADDR_W-1:0] pc_q, pc_d;
    logic [CM_ADDR_W-1:0] saddr_q, saddr_d;
    logic [CM_ADDR_W-1:0] eaddr_q, eaddr_d;
    logic [LOOP_W-1:0]    loop_q, loop_d;
    logic [LOOP_W-1:0]    iter_q, iter_d;
    logic                 ctx_valid_q;
    logic                 err_q, err_d;

    logic                 w_rd_en;
    logic                 w_done;
    logic                 w_last_pass;

    assign w_last_pass = (loop_q != '0) && (iter_q == loop_q - LOOP_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            saddr_q     <= '0;
            eaddr_q     <= '0;
            loop_q      <= '0;
            iter_q      <= '0;
            ctx_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            saddr_q     <= saddr_d;
            eaddr_q     <= eaddr_d;
            loop_q      <= loop_d;
            iter_q      <= iter_d;
            ctx_valid_q <= w_rd_en;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        saddr_d = saddr_q;
        eaddr_d = eaddr_q;
        loop_d  = loop_q;
        iter_d  = iter_q;
        err_d   = 1'b0;
        w_rd_en = 1'b0;
        w_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    if (bus.start_addr_i <= bus.end_addr_i) begin
                        saddr_d = bus.start_addr_i;
                        eaddr_d = bus.end_addr_i;
                        loop_d  = bus.loop_cnt_i;
                        pc_d    = bus.start_addr_i;
                        iter_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // Issue is suppressed in the abort cycle so no word is left in flight.
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else if (!bus.stall_i) begin
                    w_rd_en = 1'b1;
                    if (pc_q == eaddr_q) begin
                        pc_d = saddr_q;
                        if (iter_q != {LOOP_W{1'b1}}) begin
                            iter_d = iter_q + LOOP_W'(1);
                        end
                        if (w_last_pass) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        pc_d = pc_q + CM_ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                w_done  = !bus.abort_i;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.rd_cm_en_o  = w_rd_en;
    assign bus.cm_addr_o   = w_rd_en ? pc_q : '0;
    assign bus.ctx_valid_o = ctx_valid_q;
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.done_o      = w_done;
    assign bus.err_o       = err_q;
    assign bus.iter_o      = iter_q;

    cgra_context_sequencer_unpack #(
        .NUM_PE    (NUM_PE),
        .PE_CFG_W  (PE_CFG_W),
        .DM_CTRL_W (DM_CTRL_W),
        .CTX_W     (CTX_W)
    ) u_unpack (
        .ctx_valid_i  (ctx_valid_q),
        .ctx_word_i   (bus.rd_cm_data_i),
        .pe_config_o  (bus.pe_config_o),
        .dm_control_o (bus.dm_control_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_cgra_context_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cgra_context_sequencer : directed and random runs against a queue-based run model
// Revision: 1.0
// ============================================================================
module tb_cgra_context_sequencer;
    import cgra_context_sequencer_pkg::*;

    localparam int NUM_PE    = C_NUM_PE;
    localparam int PE_CFG_W  = C_PE_CFG_W;
    localparam int DM_CTRL_W = C_DM_CTRL_W;
    localparam int CM_ADDR_W = C_CM_ADDR_W;
    localparam int LOOP_W    = C_LOOP_W;
    localparam int CTX_W     = ctx_width(NUM_PE, PE_CFG_W, DM_CTRL_W);
    localparam int PE_BUS_W  = NUM_PE * PE_CFG_W;
    localparam int DEPTH     = 1 << CM_ADDR_W;
    localparam int ITER_MAX  = (1 << LOOP_W) - 1;

    logic clk = 1'b0;
    logic reset;

    cgra_context_sequencer_if #(
        .NUM_PE(NUM_PE), .PE_CFG_W(PE_CFG_W), .DM_CTRL_W(DM_CTRL_W),
        .CM_ADDR_W(CM_ADDR_W), .LOOP_W(LOOP_W)
    ) bus ();

    cgra_context_sequencer #(
        .NUM_PE(NUM_PE), .PE_CFG_W(PE_CFG_W), .DM_CTRL_W(DM_CTRL_W),
        .CM_ADDR_W(CM_ADDR_W), .LOOP_W(LOOP_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [CTX_W-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (bus.rd_cm_en_o) bus.rd_cm_data_i <= mem[bus.cm_addr_o];
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Run model: the addresses still owed in the current pass, plus issue totals.
    int               exp_q[$];
    bit               m_run, m_fin, m_vld, m_err;
    logic [CTX_W-1:0] m_word;
    int               m_s, m_e, m_loop, m_len, m_issued, m_iter;
    int               n_done, n_rd, n_busy, n_errp;

    task automatic fill_pass();
        for (int a = m_s; a <= m_e; a++) exp_q.push_back(a);
    endtask

    task automatic model_clear();
        m_run = 0; m_fin = 0; m_vld = 0; m_err = 0; m_word = '0; m_iter = 0;
        exp_q.delete();
    endtask

    task automatic step(input bit st, input bit stl, input bit ab, input bit rn);
        bit               exp_rd;
        int               exp_addr;
        logic [CTX_W-1:0] w;
        bus.start_i = st;
        bus.stall_i = stl;
        bus.abort_i = ab;
        reset       = rn;
        #1;
        exp_rd   = m_run && !m_fin && !stl && !ab;
        exp_addr = exp_rd ? exp_q[0] : 0;
        w        = m_vld ? m_word : '0;
        chk_eq("rd_cm_en",   64'(bus.rd_cm_en_o),  64'(exp_rd));
        chk_eq("cm_addr",    64'(bus.cm_addr_o),   64'(exp_addr));
        chk_eq("busy",       64'(bus.busy_o),      64'(m_run));
        chk_eq("done",       64'(bus.done_o),      64'(m_fin && !ab));
        chk_eq("ctx_valid",  64'(bus.ctx_valid_o), 64'(m_vld));
        chk_eq("err",        64'(bus.err_o),       64'(m_err));
        chk_eq("iter",       64'(bus.iter_o),      64'(m_iter));
        chk_eq("pe_config",  64'(bus.pe_config_o), 64'(w[PE_BUS_W-1:0]));
        chk_eq("dm_control", 64'(bus.dm_control_o), 64'(w[CTX_W-1:PE_BUS_W]));
        if (bus.done_o)     n_done++;
        if (bus.rd_cm_en_o) n_rd++;
        if (bus.busy_o)     n_busy++;
        if (bus.err_o)      n_errp++;

        if (!rn) begin
            model_clear();
        end else begin
            m_vld = exp_rd;
            if (exp_rd) m_word = mem[exp_addr];
            m_err = !m_run && st && !ab && (bus.start_addr_i > bus.end_addr_i);
            if (m_fin) begin
                m_run = 0;
                m_fin = 0;
            end else if (m_run) begin
                if (ab) begin
                    m_run = 0;
                    exp_q.delete();
                end else if (!stl) begin
                    void'(exp_q.pop_front());
                    m_issued++;
                    m_iter = (m_issued / m_len > ITER_MAX) ? ITER_MAX : m_issued / m_len;
                    if (exp_q.size() == 0) begin
                        if (m_loop == 0 || m_issued / m_len < m_loop) fill_pass();
                        else m_fin = 1;
                    end
                end
            end else if (st && !ab && bus.start_addr_i <= bus.end_addr_i) begin
                m_s = int'(bus.start_addr_i);
                m_e = int'(bus.end_addr_i);
                m_loop = int'(bus.loop_cnt_i);
                m_len = m_e - m_s + 1;
                m_issued = 0;
                m_iter = 0;
                exp_q.delete();
                fill_pass();
                m_run = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_dir(input int s, input int e, input int lp, input int stall_at,
                           input int stall_len, input int abort_at, input int rst_at,
                           input int ncyc);
        bus.start_addr_i = CM_ADDR_W'(s);
        bus.end_addr_i   = CM_ADDR_W'(e);
        bus.loop_cnt_i   = LOOP_W'(lp);
        n_done = 0; n_rd = 0; n_busy = 0; n_errp = 0;
        for (int c = 0; c < ncyc; c++)
            step(c == 0, (c >= stall_at) && (c < stall_at + stall_len), c == abort_at, c != rst_at);
    endtask

    initial begin
        int run_len;
        for (int i = 0; i < DEPTH; i++) mem[i] = CTX_W'({$urandom(), $urandom()});
        bus.start_i = 0; bus.stall_i = 0; bus.abort_i = 0;
        bus.start_addr_i = '0; bus.end_addr_i = '0; bus.loop_cnt_i = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_clear();
        m_len = 1;
        repeat (2) step(0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 1);

        run_dir(2, 5, 1, -1, 0, -1, -1, 8);
        chk_eq("t1_busy_cycles", 64'(n_busy), 64'd5);
        chk_eq("t1_done_count",  64'(n_done), 64'd1);
        chk_eq("t1_iter_end",    64'(bus.iter_o), 64'd1);

        run_dir(0, 1, 3, -1, 0, -1, -1, 10);
        chk_eq("t2_issues",      64'(n_rd),   64'd6);
        chk_eq("t2_done_count",  64'(n_done), 64'd1);
        chk_eq("t2_iter_end",    64'(bus.iter_o), 64'd3);

        run_dir(0, 7, 1, 5, 2, -1, -1, 14);
        chk_eq("t3_issues",      64'(n_rd),   64'd8);
        chk_eq("t3_done_count",  64'(n_done), 64'd1);

        run_dir(7, 3, 1, -1, 0, -1, -1, 4);
        chk_eq("t4_err_pulses",  64'(n_errp), 64'd1);
        chk_eq("t4_issues",      64'(n_rd),   64'd0);
        chk_eq("t4_busy_cycles", 64'(n_busy), 64'd0);

        run_dir(60, 63, 0, -1, 0, 13, -1, 16);
        chk_eq("t5_issues",      64'(n_rd),   64'd12);
        chk_eq("t5_done_count",  64'(n_done), 64'd0);
        chk_eq("t5_iter_held",   64'(bus.iter_o), 64'd3);

        run_dir(0, 7, 2, -1, 0, -1, 4, 7);
        chk_eq("t6_iter_reset",  64'(bus.iter_o), 64'd0);
        chk_eq("t6_busy_reset",  64'(bus.busy_o), 64'd0);
        run_dir(1, 2, 1, -1, 0, 0, -1, 3);
        chk_eq("t6_start_abort_busy", 64'(n_busy), 64'd0);
        chk_eq("t6_start_abort_rd",   64'(n_rd),   64'd0);

        run_dir(9, 9, 0, -1, 0, 300, -1, 302);
        chk_eq("iter_saturate", 64'(bus.iter_o), 64'(ITER_MAX));

        run_len = 0;
        for (int c = 0; c < 2000; c++) begin
            bit st, stl, ab, rn;
            int s, e;
            st = 0; ab = 0; rn = 1;
            if ($urandom_range(0, 3) == 0) begin
                s = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 7) == 0) e = $urandom_range(0, DEPTH - 1);
                else e = (s + $urandom_range(0, 5) > DEPTH - 1) ? DEPTH - 1 : s + $urandom_range(0, 5);
                bus.start_addr_i = CM_ADDR_W'(s);
                bus.end_addr_i   = CM_ADDR_W'(e);
                bus.loop_cnt_i   = LOOP_W'($urandom_range(0, 3));
                st = 1;
                if (!m_run) run_len = 0;
                if ($urandom_range(0, 9) == 0) ab = 1;
            end
            stl = ($urandom_range(0, 3) == 0);
            if (m_run) run_len++;
            if (m_run && ($urandom_range(0, 79) == 0 || run_len > 60)) ab = 1;
            if ($urandom_range(0, 399) == 0) rn = 0;
            step(st, stl, ab, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
